// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions for the cache-to-core read arbiter:
// FSM state encoding, AXI burst/response codes and cache port indices.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int NUM_PORTS = 2;
  localparam int PORT_I    = 0;  // instruction cache
  localparam int PORT_D    = 1;  // data cache

  // AXI arsize encoding for a full-width beat
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/rd_arbiter.sv
// Two-input request arbiter. Grant is combinational from the request pair.
// Build option AXI_RD_RR_EN: round-robin between the two ports using a
// last-grant register; otherwise fixed priority with the data port winning.
module rd_arbiter
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,       // arbiter result is consumed this cycle
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;

`ifdef AXI_RD_RR_EN
  logic last_gnt;

  // When both request, the port that did not win last time goes first
  always_comb begin
    gnt_idx = req[PORT_D];
    if (&req) gnt_idx = ~last_gnt;
  end

  // Remember the winner of every grant actually taken
  always_ff @(posedge clk) begin
    if (rst)                     last_gnt <= 1'b0;
    else if (take && gnt_valid)  last_gnt <= gnt_idx;
  end
`else
  // Data port has fixed priority; instruction port only wins alone
  assign gnt_idx = req[PORT_D];

  logic unused_arb;
  assign unused_arb = ^{clk, rst, take};
`endif

endmodule

// File: rtl/axi_rd_arb_demux.sv
// Two-to-one AXI4 read arbiter and R-channel demux between the I-cache
// (port 0) and D-cache (port 1). One burst outstanding at a time; R beats
// are steered to the port that owns the burst, never by m_rid.
// Build option: AXI_RD_RR_EN selects round-robin arbitration (see rd_arbiter).
module axi_rd_arb_demux
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // cache side
  input  logic [1:0]             s_arvalid,
  output logic [1:0]             s_arready,
  input  logic [1:0][ADDR_W-1:0] s_araddr,
  input  logic [1:0][7:0]        s_arlen,
  output logic [1:0]             s_rvalid,
  input  logic [1:0]             s_rready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  // AXI AR
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [7:0]             m_arlen,
  output logic [ID_W-1:0]        m_arid,
  output logic [2:0]             m_arsize,
  output logic [1:0]             m_arburst,
  // AXI R
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic [ID_W-1:0]        m_rid
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ar_req_t;

  rd_state_t state;
  ar_req_t   req_q;
  logic      owner;
  logic      gnt_valid, gnt_idx;
  logic      take, in_data;

  // Reset blanks every handshake output in the same cycle it is asserted
  assign take    = (state == IDLE) && !rst;
  assign in_data = (state == DATA) && !rst;

  rd_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (s_arvalid),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Acknowledge pulse to the winning port, only in an IDLE cycle
  assign s_arready = (take && gnt_valid) ? {gnt_idx, ~gnt_idx} : 2'b00;

  // FSM: latch the granted request, present it on AR, then own R until rlast
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      m_arvalid <= 1'b0;
      req_q     <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          owner      <= gnt_idx;
          req_q.addr <= s_araddr[gnt_idx];
          req_q.len  <= s_arlen[gnt_idx];
          m_arvalid  <= 1'b1;
          state      <= ADDR;
        end
        ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          state     <= DATA;
        end
        DATA: if (m_rvalid && m_rready && m_rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_araddr  = req_q.addr;
  assign m_arlen   = req_q.len;
  assign m_arid    = ID_W'(owner);
  assign m_arsize  = axi_size(DATA_W);
  assign m_arburst = AXI_BURST_INCR;

  // R demux: valid only toward the owner, ready only from the owner
  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign s_rvalid[p] = in_data && m_rvalid && (owner == 1'(p));
    end
  endgenerate

  assign m_rready = in_data && s_rready[owner];
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  // m_rid is expected to match owner but deliberately plays no part in routing
  logic unused_rid_mismatch;
  assign unused_rid_mismatch = in_data && m_rvalid && (m_rid != m_arid);

endmodule

// File: tb/tb_axi_rd_arb_demux.sv
// Self-checking bench for axi_rd_arb_demux: the bench plays both caches and
// the AXI slave, and a transaction-level model predicts grants, AR fields
// and beat routing every cycle.
module tb_axi_rd_arb_demux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0][AW-1:0] s_araddr;
  logic [1:0][7:0]    s_arlen;
  logic [DW-1:0]      s_rdata, m_rdata;
  logic [1:0]         s_rresp, m_rresp, m_arburst;
  logic               s_rlast, m_rlast;
  logic               m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]      m_araddr;
  logic [7:0]         m_arlen;
  logic [IW-1:0]      m_arid, m_rid;
  logic [2:0]         m_arsize;

  axi_rd_arb_demux #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  logic [1:0]    pend;           // ports currently holding a request
  logic [AW-1:0] req_addr [2];
  logic [7:0]    req_len  [2];
  int            mphase;         // 0 free, 1 address issued, 2 beats flowing
  int            mowner, last_g;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_len;
  logic [DW-1:0] bq[$];          // beats still to be returned by the slave
  logic [DW-1:0] dbase;
  int            beats_in_burst;
  int            rxn [2];
  int            grants[$];
  // stimulus knobs
  int            ar_delay, ar_wait, rv_pct, rr_pct;
  int            stall_port, stall_after, stall_left;
  logic          err_last, rand_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post_req(input int p, input logic [AW-1:0] a, input logic [7:0] l);
    pend[p]     = 1'b1;
    req_addr[p] = a;
    req_len[p]  = l;
  endtask

  // Which port the arbitration rules pick for a non-empty request set
  function automatic int pick(input logic [1:0] r, input int last);
`ifdef AXI_RD_RR_EN
    if (r == 2'b11) return 1 - last;
`else
    if (r == 2'b11) return 1;
`endif
    return r[1] ? 1 : 0;
  endfunction

  // One clock: drive caches and slave just after the edge, check mid-cycle
  task automatic step();
    int g;
    @(posedge clk); #1;
    rst       = 1'b0;
    s_arvalid = pend;
    for (int p = 0; p < 2; p++) begin
      s_araddr[p] = req_addr[p];
      s_arlen[p]  = req_len[p];
    end
    if (mphase == 1) begin
      m_arready = (ar_wait == 0);
      if (ar_wait > 0) ar_wait--;
    end else m_arready = 1'($urandom_range(0, 1));
    if (mphase == 2) begin
      m_rvalid = ($urandom_range(0, 99) < rv_pct);
      m_rdata  = bq[0];
      m_rlast  = (bq.size() == 1);
      m_rresp  = (m_rlast && err_last) ? 2'b10 : 2'b00;
      m_rid    = IW'(mowner);
    end else begin
      // stray R activity outside a burst must not reach either cache
      m_rvalid = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
      m_rlast  = 1'($urandom_range(0, 1));
      m_rresp  = 2'b00;
      m_rid    = '0;
    end
    for (int p = 0; p < 2; p++) s_rready[p] = ($urandom_range(0, 99) < rr_pct);
    if (mphase == 2 && stall_left > 0 && beats_in_burst >= stall_after) begin
      s_rready[stall_port] = 1'b0;
      stall_left--;
    end
    #1;
    case (mphase)
      0: begin
        chk("arvalid_idle", m_arvalid, 0);
        chk("rready_idle", m_rready, 0);
        chk("rvalid_idle", s_rvalid, 0);
        if (pend != 2'b00) begin
          g = pick(pend, last_g);
          chk("grant", s_arready, (g == 1) ? 2'b10 : 2'b01);
          mphase   = 1;
          mowner   = g;
          last_g   = g;
          exp_addr = req_addr[g];
          exp_len  = req_len[g];
          pend[g]  = 1'b0;
          ar_wait  = (ar_delay >= 0) ? ar_delay : $urandom_range(0, 3);
          grants.push_back(g);
        end else chk("arready_none", s_arready, 0);
      end
      1: begin
        chk("arready_addr", s_arready, 0);
        chk("arvalid", m_arvalid, 1);
        chk("araddr", m_araddr, exp_addr);
        chk("arlen", m_arlen, exp_len);
        chk("arid", m_arid, mowner);
        chk("rready_addr", m_rready, 0);
        chk("rvalid_addr", s_rvalid, 0);
        if (m_arready) begin
          if (rand_data) dbase = $urandom;
          for (int i = 0; i <= int'(exp_len); i++) bq.push_back(dbase + DW'(i));
          beats_in_burst = 0;
          mphase = 2;
        end
      end
      default: begin
        chk("arready_busy", s_arready, 0);
        chk("arvalid_data", m_arvalid, 0);
        chk("rvalid_route", s_rvalid, m_rvalid ? ((mowner == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk("rready_route", m_rready, s_rready[mowner]);
        if (m_rvalid) begin
          chk("rlast", s_rlast, m_rlast);
          chk("rresp", s_rresp, m_rresp);
        end
        if (m_rvalid && s_rready[mowner]) begin
          chk("beat_data", s_rdata, dbase + DW'(beats_in_burst));
          void'(bq.pop_front());
          beats_in_burst++;
          rxn[mowner]++;
          if (beats_in_burst == int'(exp_len) + 1) mphase = 0;
        end
      end
    endcase
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (!(mphase == 0 && pend == 2'b00) && n < max) begin
      step();
      n++;
    end
    chk("drain_done", (mphase == 0 && pend == 2'b00), 1);
  endtask

  initial begin
    int g0, rx0, rx1, n;
    rst = 1'b1; s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
    pend = '0; req_addr[0] = '0; req_addr[1] = '0; req_len[0] = '0; req_len[1] = '0;
    mphase = 0; mowner = 0; last_g = 0; rxn[0] = 0; rxn[1] = 0; beats_in_burst = 0;
    ar_delay = 0; ar_wait = 0; rv_pct = 100; rr_pct = 100;
    stall_port = 0; stall_after = 0; stall_left = 0; err_last = 0; rand_data = 0; dbase = '0;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arlen", m_arlen, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("arsize", m_arsize, 3'd2);
    chk("arburst", m_arburst, 2'b01);
    step();

    // I-cache alone: 4 beats A0..A3, slave arready after 2 cycles
    ar_delay = 2; dbase = 32'hA0; rx0 = rxn[0]; rx1 = rxn[1];
    post_req(0, 32'h1FC0_0000, 8'd3);
    run_idle(100);
    chk("t1_beats_p0", rxn[0] - rx0, 4);
    chk("t1_beats_p1", rxn[1] - rx1, 0);

    // both ports request together, two rounds: grants 1,0,1,0
    ar_delay = -1; rand_data = 1; rv_pct = 70; rr_pct = 80; g0 = grants.size();
    for (int r = 0; r < 2; r++) begin
      post_req(0, 32'h0000_1000 + AW'(r * 64), 8'd2);
      post_req(1, 32'h8000_2000 + AW'(r * 64), 8'd1);
      run_idle(200);
    end
    chk("t2_ngrants", grants.size() - g0, 4);
    for (int k = 0; k < 4 && g0 + k < grants.size(); k++)
      chk("t2_grant_order", grants[g0 + k], (k % 2 == 0) ? 1 : 0);

    // D-cache stalls 3 cycles mid-burst of 8 beats
    rv_pct = 100; rr_pct = 100; stall_port = 1; stall_after = 3; stall_left = 3;
    rx1 = rxn[1];
    post_req(1, 32'h4000_0100, 8'd7);
    run_idle(100);
    chk("t3_beats_p1", rxn[1] - rx1, 8);
    chk("t3_stall_used", stall_left, 0);

    // request arriving during DATA waits for the IDLE cycle after rlast
    rv_pct = 60; rr_pct = 90; g0 = grants.size();
    post_req(0, 32'h1FC0_0400, 8'd5);
    n = 0;
    while (mphase != 2 && n < 50) begin step(); n++; end
    chk("t4_reach_data", mphase, 2);
    post_req(1, 32'h4000_0800, 8'd2);
    run_idle(200);
    chk("t4_ngrants", grants.size() - g0, 2);
    if (grants.size() - g0 == 2) chk("t4_second_grant", grants[g0 + 1], 1);

    // reset at beat 2 of 8 abandons the burst
    rv_pct = 100; rr_pct = 100;
    post_req(1, 32'h4000_1000, 8'd7);
    n = 0;
    while (!(mphase == 2 && beats_in_burst == 2) && n < 50) begin step(); n++; end
    chk("t5_reach_beat2", beats_in_burst, 2);
    @(posedge clk); #1;
    rst = 1'b1; s_arvalid = '0; s_rready = 2'b11;
    m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hDEAD_BEEF;
    pend = '0; mphase = 0; last_g = 0; bq.delete();
    step();
    chk("t5_araddr_rst", m_araddr, 0);
    rx0 = rxn[0];
    dbase = 32'h5000; rand_data = 0;
    post_req(0, 32'h1FC0_0800, 8'd3);
    run_idle(100);
    chk("t5_fresh_beats", rxn[0] - rx0, 4);

    // SLVERR on the last beat reaches the owner with rlast
    err_last = 1; rand_data = 1;
    post_req(0, 32'h1FC0_0C00, 8'd2);
    run_idle(100);
    err_last = 0;

    // random traffic
    ar_delay = -1;
    for (int it = 0; it < 600; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 5) == 0)
          post_req(p, $urandom, 8'($urandom_range(0, 7)));
      rv_pct = $urandom_range(30, 100);
      rr_pct = $urandom_range(30, 100);
      err_last = ($urandom_range(0, 3) == 0);
      step();
    end
    run_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
